// File: rtl/axis_pkg.sv
// Shared stream helpers: width helpers and the common stream localparams.
package axis_pkg;

  localparam int AXIS_DATA_W_DEFAULT     = 8;
  localparam int AXIS_DEPTH_LOG2_DEFAULT = 2;

`ifdef AXIS_FIFO_LAST_EN
  localparam int AXIS_LAST_W = 1;
`else
  localparam int AXIS_LAST_W = 0;
`endif

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
  function automatic int AXIS_SIZE_W(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module axis_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo.sv
// First-word fall-through AXI-stream FIFO of 2**DEPTH_LOG2 entries.
// Define AXIS_FIFO_LAST_EN to add the ilast/olast end-of-packet sideband.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W_DEFAULT,
  parameter int DEPTH_LOG2 = AXIS_DEPTH_LOG2_DEFAULT
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic [AXIS_SIZE_W(DEPTH_LOG2)-1:0]  size,
  input  logic [DATA_WIDTH-1:0]               idata,
  input  logic                                ivalid,
  output logic                                iready,
  output logic [DATA_WIDTH-1:0]               odata,
  output logic                                ovalid,
  input  logic                                oready
`ifdef AXIS_FIFO_LAST_EN
  ,
  input  logic                                ilast,
  output logic                                olast
`endif
);

  localparam int SW = AXIS_SIZE_W(DEPTH_LOG2);
  localparam int MW = DATA_WIDTH + AXIS_LAST_W;
  localparam logic [SW-1:0] FULL = SW'(1) << DEPTH_LOG2;

  logic                  push;
  logic                  pop;
  logic [SW-1:0]         size_next;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [MW-1:0]         wdata;
  logic [MW-1:0]         rdata;

  assign push = ivalid && iready;
  assign pop  = ovalid && oready;

  always_comb begin
    size_next = size;
    case ({push, pop})
      2'b10:   size_next = size + SW'(1);
      2'b01:   size_next = size - SW'(1);
      default: size_next = size;
    endcase
  end

  // Flags are registered from size_next, so a pop on a full FIFO only frees iready next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      size   <= '0;
      iready <= 1'b0;
      ovalid <= 1'b0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      size   <= size_next;
      iready <= (size_next != FULL);
      ovalid <= (size_next != '0);
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
    end
  end

`ifdef AXIS_FIFO_LAST_EN
  assign wdata = {ilast, idata};
  assign odata = rdata[DATA_WIDTH-1:0];
  assign olast = rdata[DATA_WIDTH];
`else
  assign wdata = idata;
  assign odata = rdata;
`endif

  axis_fifo_ram #(
    .WIDTH  (MW),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (push && !reset),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

endmodule
